// File: rtl/dti_quantize.sv
// DTI quantizer: drops NBITS LSBs with floor / round-half-up / round-half-even,
// optional saturation, and a registered 2-entry skid buffer on the output.
module dti_quantize #(
    parameter int DIN        = 16,
    parameter int NBITS      = 4,
    parameter int SIGNED     = 1,
    parameter int MODE       = 0,
    parameter int SATURATE   = 1,
    parameter int KEEP_WIDTH = 1,
    parameter int CNT_W      = 16,
    localparam int DOUT_W    = (KEEP_WIDTH != 0) ? DIN : DIN - NBITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIN-1:0]    din_data_i,
    input  logic              din_valid_i,
    output logic              din_ready_o,
    output logic [DOUT_W-1:0] dout_data_o,
    output logic              dout_valid_o,
    input  logic              dout_ready_i,
    input  logic              sat_clr_i,
    output logic [CNT_W-1:0]  sat_cnt_o
);

    localparam int KW = DIN - NBITS;

    logic [DOUT_W-1:0] qdata;
    logic              sat_hit;

    generate
        if (DIN < 2 || NBITS < 0 || NBITS >= DIN || MODE < 0 || MODE > 2) begin : g_bad_cfg
            $error("dti_quantize: illegal configuration (need DIN>=2, 0<=NBITS<DIN, MODE<=2)");
        end

        if (NBITS == 0) begin : g_pass
            assign qdata   = din_data_i;
            assign sat_hit = 1'b0;
        end else begin : g_quant
            localparam logic [NBITS-1:0] HALF = NBITS'(1) << (NBITS - 1);
            localparam logic [KW-1:0]    MAXV = (SIGNED != 0) ? ({KW{1'b1}} >> 1) : {KW{1'b1}};

            logic [KW:0]      k_ext;
            logic [KW:0]      q;
            logic [NBITS-1:0] r;
            logic             inc;
            logic             ovf;
            logic [KW-1:0]    kept;

            // One guard bit above the kept field: only +1 rounding can overflow it.
            always_comb begin
                r     = din_data_i[NBITS-1:0];
                k_ext = {(SIGNED != 0) ? din_data_i[DIN-1] : 1'b0, din_data_i[DIN-1:NBITS]};
                case (MODE)
                    1:       inc = r[NBITS-1];
                    2:       inc = (r > HALF) || ((r == HALF) && k_ext[0]);
                    default: inc = 1'b0;
                endcase
                q    = k_ext + {{KW{1'b0}}, inc};
                ovf  = (SIGNED != 0) ? (!q[KW] && q[KW-1]) : q[KW];
                kept = ((SATURATE != 0) && ovf) ? MAXV : q[KW-1:0];
            end

            assign sat_hit = (SATURATE != 0) && ovf;

            if (KEEP_WIDTH != 0) begin : g_keep
                assign qdata = {kept, {NBITS{1'b0}}};
            end else begin : g_narrow
                assign qdata = kept;
            end
        end
    endgenerate

    logic [DOUT_W-1:0] main_q, main_d, skid_q, skid_d;
    logic              main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic              rdy_q, rdy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              acc, pop, sat_acc;

    assign acc     = din_valid_i && rdy_q;
    assign pop     = main_vld_q && dout_ready_i;
    assign sat_acc = acc && sat_hit;

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (!main_vld_q) begin
            if (acc) begin
                main_d     = qdata;
                main_vld_d = 1'b1;
            end
        end else if (!skid_vld_q) begin
            if (pop && acc) begin
                main_d = qdata;
            end else if (pop) begin
                main_vld_d = 1'b0;
            end else if (acc) begin
                skid_d     = qdata;
                skid_vld_d = 1'b1;
            end
        end else if (pop) begin
            // FULL: ready is low, so nothing new can arrive while draining skid.
            main_d     = skid_q;
            skid_vld_d = 1'b0;
        end
        rdy_d = !skid_vld_d;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (sat_clr_i) begin
            cnt_d = sat_acc ? CNT_W'(1) : '0;
        end else if (sat_acc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= rdy_d;
            cnt_q      <= cnt_d;
        end
        main_q <= main_d;
        skid_q <= skid_d;
    end

    assign din_ready_o  = rdy_q;
    assign dout_data_o  = main_q;
    assign dout_valid_o = main_vld_q;
    assign sat_cnt_o    = cnt_q;

endmodule

// File: tb/tb_dti_quantize.sv
// Directed bench for dti_quantize: six DIN=8/NBITS=3 variants share one stimulus stream.
module tb_dti_quantize;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din_data;
    logic       din_valid;
    logic       dout_ready;
    logic       sat_clr;

    logic [7:0]  d0, d1, d2, d3, d4;
    logic [4:0]  d5;
    logic [5:0]  v, r;
    logic [15:0] c0, c2, c3, c4, c5;
    logic [1:0]  c1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // u0 floor, u1 half-up (CNT_W=2), u2 half-even, u3 half-up wrap, u4 unsigned, u5 narrow output
    dti_quantize #(.DIN(8), .NBITS(3), .SIGNED(1), .MODE(0), .SATURATE(1), .KEEP_WIDTH(1), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .din_data_i(din_data), .din_valid_i(din_valid), .din_ready_o(r[0]),
        .dout_data_o(d0), .dout_valid_o(v[0]), .dout_ready_i(dout_ready), .sat_clr_i(sat_clr), .sat_cnt_o(c0));
    dti_quantize #(.DIN(8), .NBITS(3), .SIGNED(1), .MODE(1), .SATURATE(1), .KEEP_WIDTH(1), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .din_data_i(din_data), .din_valid_i(din_valid), .din_ready_o(r[1]),
        .dout_data_o(d1), .dout_valid_o(v[1]), .dout_ready_i(dout_ready), .sat_clr_i(sat_clr), .sat_cnt_o(c1));
    dti_quantize #(.DIN(8), .NBITS(3), .SIGNED(1), .MODE(2), .SATURATE(1), .KEEP_WIDTH(1), .CNT_W(16)) u2 (
        .clk(clk), .rst(rst), .din_data_i(din_data), .din_valid_i(din_valid), .din_ready_o(r[2]),
        .dout_data_o(d2), .dout_valid_o(v[2]), .dout_ready_i(dout_ready), .sat_clr_i(sat_clr), .sat_cnt_o(c2));
    dti_quantize #(.DIN(8), .NBITS(3), .SIGNED(1), .MODE(1), .SATURATE(0), .KEEP_WIDTH(1), .CNT_W(16)) u3 (
        .clk(clk), .rst(rst), .din_data_i(din_data), .din_valid_i(din_valid), .din_ready_o(r[3]),
        .dout_data_o(d3), .dout_valid_o(v[3]), .dout_ready_i(dout_ready), .sat_clr_i(sat_clr), .sat_cnt_o(c3));
    dti_quantize #(.DIN(8), .NBITS(3), .SIGNED(0), .MODE(1), .SATURATE(1), .KEEP_WIDTH(1), .CNT_W(16)) u4 (
        .clk(clk), .rst(rst), .din_data_i(din_data), .din_valid_i(din_valid), .din_ready_o(r[4]),
        .dout_data_o(d4), .dout_valid_o(v[4]), .dout_ready_i(dout_ready), .sat_clr_i(sat_clr), .sat_cnt_o(c4));
    dti_quantize #(.DIN(8), .NBITS(3), .SIGNED(1), .MODE(1), .SATURATE(1), .KEEP_WIDTH(0), .CNT_W(16)) u5 (
        .clk(clk), .rst(rst), .din_data_i(din_data), .din_valid_i(din_valid), .din_ready_o(r[5]),
        .dout_data_o(d5), .dout_valid_o(v[5]), .dout_ready_i(dout_ready), .sat_clr_i(sat_clr), .sat_cnt_o(c5));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] tin [7] = '{8'h5F, 8'hF4, 8'h5C, 8'h5B, 8'h54, 8'h7C, 8'hFC};
    logic [7:0] e0  [7] = '{8'h58, 8'hF0, 8'h58, 8'h58, 8'h50, 8'h78, 8'hF8};
    logic [7:0] e1  [7] = '{8'h60, 8'hF8, 8'h60, 8'h58, 8'h58, 8'h78, 8'h00};
    logic [7:0] e2  [7] = '{8'h60, 8'hF0, 8'h60, 8'h58, 8'h50, 8'h78, 8'h00};
    logic [7:0] e3  [7] = '{8'h60, 8'hF8, 8'h60, 8'h58, 8'h58, 8'h80, 8'h00};
    logic [7:0] e4  [7] = '{8'h60, 8'hF8, 8'h60, 8'h58, 8'h58, 8'h80, 8'hF8};
    logic [4:0] e5  [7] = '{5'h0C, 5'h1F, 5'h0C, 5'h0B, 5'h0B, 5'h0F, 5'h00};

    initial begin
        rst = 1'b1; din_data = 8'h00; din_valid = 1'b0; dout_ready = 1'b1; sat_clr = 1'b0;
        step(); step();
        chk("reset_valid", 32'(v), 32'h0);
        chk("reset_ready", 32'(r), 32'h0);
        chk("reset_cnt", 32'(c1), 32'h0);
        rst = 1'b0;
        step();
        chk("ready_after_reset", 32'(r), 32'h3F);

        // Rounding table: one word per cycle, each visible one cycle after acceptance.
        din_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            din_data = tin[i];
            step();
            chk($sformatf("q%0d_valid", i), 32'(v), 32'h3F);
            chk($sformatf("q%0d_mode0", i), 32'(d0), 32'(e0[i]));
            chk($sformatf("q%0d_mode1", i), 32'(d1), 32'(e1[i]));
            chk($sformatf("q%0d_mode2", i), 32'(d2), 32'(e2[i]));
            chk($sformatf("q%0d_wrap", i), 32'(d3), 32'(e3[i]));
            chk($sformatf("q%0d_unsigned", i), 32'(d4), 32'(e4[i]));
            chk($sformatf("q%0d_narrow", i), 32'(d5), 32'(e5[i]));
            if (i == 5) begin
                chk("sat_0x7C_cnt_mode1", 32'(c1), 32'h1);
                chk("sat_0x7C_cnt_wrap", 32'(c3), 32'h0);
            end
        end
        chk("cnt_mode0", 32'(c0), 32'h0);
        chk("cnt_mode2", 32'(c2), 32'h1);
        chk("cnt_unsigned", 32'(c4), 32'h1);
        chk("cnt_narrow", 32'(c5), 32'h1);
        din_valid = 1'b0;
        step();
        chk("drain_valid", 32'(v[1]), 32'h0);

        // Backpressure: two words land in main+skid, the third waits.
        dout_ready = 1'b0; din_valid = 1'b1; din_data = 8'h08;
        step();
        chk("bp_a_data", 32'(d1), 32'h08);
        chk("bp_a_ready", 32'(r[1]), 32'h1);
        din_data = 8'h10;
        step();
        chk("bp_b_data", 32'(d1), 32'h08);
        chk("bp_b_ready", 32'(r[1]), 32'h0);
        din_data = 8'h18;
        step();
        chk("bp_c_hold", 32'(d1), 32'h08);
        chk("bp_c_valid", 32'(v[1]), 32'h1);
        chk("bp_c_ready", 32'(r[1]), 32'h0);
        dout_ready = 1'b1;
        step();
        chk("bp_d_data", 32'(d1), 32'h10);
        chk("bp_d_ready", 32'(r[1]), 32'h1);
        step();
        chk("bp_e_data", 32'(d1), 32'h18);
        din_data = 8'h20;
        step();
        chk("bp_f_data", 32'(d1), 32'h20);
        din_valid = 1'b0;
        step();
        chk("bp_g_empty", 32'(v[1]), 32'h0);

        // Sticky 2-bit counter, currently 1.
        din_valid = 1'b1; din_data = 8'h7C;
        for (int i = 0; i < 5; i++) step();
        chk("cnt_sticky", 32'(c1), 32'h3);
        sat_clr = 1'b1;
        step();
        chk("cnt_clr_with_sat", 32'(c1), 32'h1);
        din_valid = 1'b0;
        step();
        chk("cnt_clr_alone", 32'(c1), 32'h0);
        sat_clr = 1'b0;

        // Reset with the buffer full.
        dout_ready = 1'b0; din_valid = 1'b1; din_data = 8'h7C;
        step(); step();
        chk("pre_rst_full", 32'(r[1]), 32'h0);
        chk("pre_rst_cnt", 32'(c1), 32'h2);
        rst = 1'b1; din_valid = 1'b0;
        step();
        chk("rst_valid", 32'(v[1]), 32'h0);
        chk("rst_cnt", 32'(c1), 32'h0);
        chk("rst_ready", 32'(r[1]), 32'h0);
        rst = 1'b0; dout_ready = 1'b1;
        step();
        chk("post_rst_ready", 32'(r[1]), 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("post_rst_quiet%0d", i), 32'(v[1]), 32'h0);
        end
        din_valid = 1'b1; din_data = 8'h5C;
        step();
        chk("post_rst_word", 32'(d1), 32'h60);
        chk("post_rst_word_valid", 32'(v[1]), 32'h1);
        din_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
